barrel_shifter_pipe: RTL and testbench
======================================

Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined multi-function barrel shifter. It supports rotate right and left, logical shift right and left, and arithmetic shift right, with a valid/ready handshake on both sides. It uses one right-rotate/shift core. Left operations are done by reversing the bits before and after the core. It sits in datapaths that need one shift per clock at full throughput, with back-pressure from the consumer.

Parameters:
- WIDTH, 8: data width in bits. Must be a power of two and at least 4.
- AW, $clog2(WIDTH): shift-amount width; derived, do not override.
- L, AW: number of pipeline stages. Stage k applies amt bit k-1, a shift of 2^(k-1).

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept the input this cycle
- in_data  in  WIDTH  operand
- in_amt  in  AW  shift/rotate amount, 0..WIDTH-1
- in_op  in  3  operation: 000 ROR, 001 ROL, 010 SRL, 011 SLL, 100 SRA, 101..111 PASS
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- out_zero  out  1  out_data equals all zeros
- out_op  out  3  in_op carried with the result

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits = 0; all data, amt, op and fill registers = 0. Hence out_valid = 0, out_data = 0, out_zero = 0, out_op = 0.
- in_ready may be high during reset. No transfer occurs while reset_n is low.
- Reset mid-operation: all in-flight words are discarded. No partial result is ever presented.
- Transfer rules: an input transfer occurs when in_valid and in_ready are both high. An output transfer occurs when out_valid and out_ready are both high.
- Pipeline stages are S1..SL; SL drives the out_* ports directly from registers.
- adv_L = !v_L | out_ready.
- adv_k = !v_k | adv_(k+1), for k < L.
- in_ready = adv_1. This is a combinational path from out_ready; it is accepted.
- When adv_k is true, stage k loads from stage k-1 (S1 loads from the input) and v_k takes the upstream valid. Otherwise stage k holds.
- A stalled stage holds its data, amt, op and fill bits exactly.
- Throughput is one word per clock while out_ready stays high.
- Latency: a word accepted on rising edge E is presented with out_valid = 1 after edge E+L-1.
  - For WIDTH=8 this is 3 stages; out_valid is visible 2 cycles after the accept cycle.
- Order is preserved. No word may be dropped or duplicated under any out_ready pattern.
- Pre-stage, combinational at the input:
  - If op is ROL or SLL, the operand is bit-reversed (bit i goes to bit WIDTH-1-i). Otherwise it passes unchanged.
  - The fill bit is in_data[WIDTH-1] for SRA, and 0 for SRL and SLL.
  - The mode is one of: rotate (ROR, ROL), shift (SRL, SLL, SRA), or pass.
- Stage k, when amt[k-1] = 1, with s = 2^(k-1):
  - Rotate mode: rotate right by s.
  - Shift mode: shift right by s, filling the top s bits with the fill bit.
  - Pass mode, or amt[k-1] = 0: data unchanged.
- Post-stage, combinational from the SL register:
  - out_data is the SL data bit-reversed when the SL op is ROL or SLL. Otherwise it is the SL data unchanged.
  - out_zero = (out_data == 0) & out_valid.
- Amount 0 returns in_data unchanged for every op.
- An amount of WIDTH or more cannot be expressed; amt is AW bits wide.
- SRA on a negative operand by WIDTH-1 returns all ones.
- Simultaneous output transfer and input transfer on a full pipeline: both occur in the same cycle and occupancy is unchanged.
- out_valid must not depend combinationally on in_valid.

Test Plan:
- WIDTH=8; after reset, reset_n=1. Send 0x96 with amt=3 for each op, holding out_ready=1. Required results in order:
  - ROR: 0xD2
  - ROL: 0xB4
  - SRL: 0x12
  - SLL: 0xB0
  - SRA: 0xF2
  - op=101: 0x96
  - All results appear on consecutive cycles, with out_valid first high 2 cycles after the first accept.
- amt=0, data 0x5A, all ops -> 0x5A each. SRA on 0x80 with amt=7 -> 0xFF. SLL on 0x80 with amt=1 -> 0x00 with out_zero=1.
- Back-pressure: stream 10 words, each with amt equal to the word's index mod 8. Hold out_ready=0 for 5 cycles mid-stream.
  - in_ready falls once 3 words are buffered.
  - No loss, no duplication, order preserved, held outputs stable.
  - Then toggle out_ready randomly and compare against a reference model.
- Full pipeline with in_valid=1 and out_ready=1 held: an accept and a deliver occur every cycle for 20 cycles.
- Pull reset_n low while 3 words are in flight and out_ready=0:
  - out_valid and out_data drop to 0 immediately, without waiting for a clock edge.
  - After release, the next accepted word is delivered correctly after 2 cycles.
- WIDTH=32: exhaustive amt 0..31 for ROL and SRA on 0x8000_0001. Check latency = 5 stages.

Source files
------------

// File: rtl/barrel_shifter_pipe_if.sv
// Operand (in_*) and result (out_*) handshake bundle for barrel_shifter_pipe.
// master drives operands and consumes results; slave is the shifter side.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic [2:0]       out_op;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_op
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_op
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined ROR/ROL/SRL/SLL/SRA/PASS on one right-shift core; L stages, one word per clock.
// A stage loads when it is empty or everything downstream advances; in_ready follows out_ready combinationally.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH),
  parameter int L     = AW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  barrel_shifter_pipe_if.slave bus
);

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  logic             v_q      [L];
  logic [WIDTH-1:0] d_q      [L];
  logic [AW-1:0]    amt_q    [L];
  logic [2:0]       op_q     [L];
  logic             fill_q   [L];

  logic             src_v    [L];
  logic [WIDTH-1:0] src_d    [L];
  logic [AW-1:0]    src_amt  [L];
  logic [2:0]       src_op   [L];
  logic             src_fill [L];
  logic [WIDTH-1:0] nxt_d    [L];
  logic             adv      [L];
  logic             room;

  logic [WIDTH-1:0] pre_d;
  logic             pre_fill;
  logic [WIDTH-1:0] out_d;

  function automatic logic is_left(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_SLL);
  endfunction

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  // Stage k moves right by 2^k; left ops arrive here already mirrored.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d, input logic en,
                                                  input logic [2:0] op, input logic fill,
                                                  input int k);
    logic [WIDTH-1:0] r;
    int               s;
    s = 1 << k;
    r = d;
    if (en) begin
      case (op)
        OP_ROR, OP_ROL:         r = (d >> s) | (d << (WIDTH - s));
        OP_SRL, OP_SLL, OP_SRA: r = (d >> s) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> s));
        default:                r = d;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    pre_d    = is_left(bus.in_op) ? bit_rev(bus.in_data) : bus.in_data;
    pre_fill = (bus.in_op == OP_SRA) && bus.in_data[WIDTH-1];
  end

  always_comb begin
    src_v[0]    = bus.in_valid;
    src_d[0]    = pre_d;
    src_amt[0]  = bus.in_amt;
    src_op[0]   = bus.in_op;
    src_fill[0] = pre_fill;
    for (int k = 1; k < L; k++) begin
      src_v[k]    = v_q[k-1];
      src_d[k]    = d_q[k-1];
      src_amt[k]  = amt_q[k-1];
      src_op[k]   = op_q[k-1];
      src_fill[k] = fill_q[k-1];
    end
    for (int k = 0; k < L; k++) begin
      nxt_d[k] = shift_step(src_d[k], src_amt[k][k], src_op[k], src_fill[k], k);
    end
  end

  // Ripple the advance condition from the consumer back to the input.
  always_comb begin
    room = bus.out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      room   = !v_q[k] || room;
      adv[k] = room;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < L; k++) begin
        v_q[k]    <= 1'b0;
        d_q[k]    <= '0;
        amt_q[k]  <= '0;
        op_q[k]   <= '0;
        fill_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < L; k++) begin
        if (adv[k]) begin
          v_q[k]    <= src_v[k];
          d_q[k]    <= nxt_d[k];
          amt_q[k]  <= src_amt[k];
          op_q[k]   <= src_op[k];
          fill_q[k] <= src_fill[k];
        end
      end
    end
  end

  assign out_d         = is_left(op_q[L-1]) ? bit_rev(d_q[L-1]) : d_q[L-1];
  assign bus.out_data  = out_d;
  assign bus.out_valid = v_q[L-1];
  assign bus.out_op    = op_q[L-1];
  assign bus.out_zero  = (out_d == '0) && v_q[L-1];
  assign bus.in_ready  = adv[0];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at WIDTH=8 and WIDTH=32 with a scoreboard for streaming phases.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrel_shifter_pipe_if #(.WIDTH(8))  b8 ();
  barrel_shifter_pipe_if #(.WIDTH(32)) b32 ();

  barrel_shifter_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(rst_n), .bus(b8));
  barrel_shifter_pipe #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(rst_n), .bus(b32));

  logic        sel32 = 1'b0;
  logic        d_valid, d_ordy;
  logic [31:0] d_data;
  logic [4:0]  d_amt;
  logic [2:0]  d_op;

  assign b8.in_valid   = d_valid & ~sel32;
  assign b8.in_data    = d_data[7:0];
  assign b8.in_amt     = d_amt[2:0];
  assign b8.in_op      = d_op;
  assign b8.out_ready  = d_ordy;
  assign b32.in_valid  = d_valid & sel32;
  assign b32.in_data   = d_data;
  assign b32.in_amt    = d_amt;
  assign b32.in_op     = d_op;
  assign b32.out_ready = d_ordy;

  logic        o_in_ready, o_valid, o_zero;
  logic [31:0] o_data;
  logic [2:0]  o_op;
  assign o_in_ready = sel32 ? b32.in_ready  : b8.in_ready;
  assign o_valid    = sel32 ? b32.out_valid : b8.out_valid;
  assign o_zero     = sel32 ? b32.out_zero  : b8.out_zero;
  assign o_op       = sel32 ? b32.out_op    : b8.out_op;
  assign o_data     = sel32 ? b32.out_data  : {24'b0, b8.out_data};

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Direct per-op formulas, independent of the mirror-and-rotate structure.
  function automatic logic [31:0] ref_op(input int w, input logic [31:0] d, input int a,
                                         input logic [2:0] op);
    logic [31:0] mask, r;
    logic        sgn;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sgn  = d[w-1];
    case (op)
      3'd0:    r = ((d >> a) | (d << (w - a))) & mask;
      3'd1:    r = ((d << a) | (d >> (w - a))) & mask;
      3'd2:    r = d >> a;
      3'd3:    r = (d << a) & mask;
      3'd4:    r = (d >> a) | (sgn ? (mask & ~(mask >> a)) : 32'd0);
      default: r = d;
    endcase
    return r;
  endfunction

  logic [31:0] v_dat [64];
  logic [4:0]  v_amt [64];
  logic [2:0]  v_op  [64];
  logic [31:0] v_exp [64];
  int          nv;

  task automatic add_vec(input logic [31:0] dat, input int amt, input logic [2:0] op,
                         input logic [31:0] exp);
    v_dat[nv] = dat;
    v_amt[nv] = 5'(amt);
    v_op[nv]  = op;
    v_exp[nv] = exp;
    nv++;
  endtask

  // Back-to-back stream with out_ready high; word j must appear exactly lat cycles after its drive cycle.
  task automatic burst(input int n);
    int lat;
    int j;
    lat    = sel32 ? 5 : 3;
    d_ordy = 1'b1;
    for (int c = 0; c <= n + lat; c++) begin
      if (c < n) begin
        d_valid = 1'b1;
        d_data  = v_dat[c];
        d_amt   = v_amt[c];
        d_op    = v_op[c];
      end else begin
        d_valid = 1'b0;
      end
      #2;
      if (c < n) check("burst_in_ready", o_in_ready, 1);
      j = c - lat;
      if (j >= 0 && j < n) begin
        check("burst_valid", o_valid, 1);
        check("burst_data", o_data, v_exp[j]);
        check("burst_op", o_op, v_op[j]);
        check("burst_zero", o_zero, v_exp[j] == 0);
      end else begin
        check("burst_valid_idle", o_valid, 0);
      end
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
  endtask

  // Scoreboard for the 8-bit streaming phases, sampled mid-cycle.
  logic        mon_en = 1'b0;
  logic [31:0] exp_q [$];
  logic [2:0]  eop_q [$];
  int          occ = 0, n_acc = 0, n_del = 0;
  logic        held = 1'b0;
  logic [31:0] held_dat;
  logic [31:0] e_dat;
  logic [2:0]  e_op;

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_in_ready", o_in_ready, d_ordy || occ < 3);
      if (held) begin
        check("mon_hold_valid", o_valid, 1);
        check("mon_hold_data", o_data, held_dat);
      end
      held     = o_valid && !d_ordy;
      held_dat = o_data;
      if (o_valid && d_ordy) begin
        check("mon_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_dat = exp_q.pop_front();
          e_op  = eop_q.pop_front();
          check("mon_data", o_data, e_dat);
          check("mon_op", o_op, e_op);
          check("mon_zero", o_zero, e_dat == 0);
        end
        occ--;
        n_del++;
      end
      if (d_valid && o_in_ready) begin
        exp_q.push_back(ref_op(8, {24'b0, d_data[7:0]}, int'(d_amt[2:0]), d_op));
        eop_q.push_back(d_op);
        occ++;
        n_acc++;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    int   idx;
    logic acc;

    rst_n = 1'b0; d_valid = 1'b0; d_ordy = 1'b0; d_data = '0; d_amt = '0; d_op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_zero", o_zero, 0);
    check("rst_op", o_op, 0);
    check("rst_valid32", b32.out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", o_valid, 0);

    // 0x96 by 3 through every op.
    nv = 0;
    add_vec(32'h96, 3, 3'b000, 32'hD2);
    add_vec(32'h96, 3, 3'b001, 32'hB4);
    add_vec(32'h96, 3, 3'b010, 32'h12);
    add_vec(32'h96, 3, 3'b011, 32'hB0);
    add_vec(32'h96, 3, 3'b100, 32'hF2);
    add_vec(32'h96, 3, 3'b101, 32'h96);
    burst(nv);

    // Zero amount, SRA to all ones, SLL to zero.
    nv = 0;
    for (int op = 0; op < 8; op++) add_vec(32'h5A, 0, 3'(op), 32'h5A);
    add_vec(32'h80, 7, 3'b100, 32'hFF);
    add_vec(32'h80, 1, 3'b011, 32'h00);
    burst(nv);

    // Back-pressure: 10 words, consumer stalls for 5 cycles mid-stream.
    mon_en = 1'b1;
    idx = 0;
    for (int c = 0; idx < 10 && c < 200; c++) begin
      d_ordy  = !(c >= 4 && c < 9);
      d_valid = 1'b1;
      d_data  = 32'((idx + 1) * 17);
      d_amt   = 5'(idx % 8);
      d_op    = 3'(idx % 6);
      #1;
      acc = o_in_ready;
      if (c >= 4 && c < 9) begin
        check("bp_in_ready_low", o_in_ready, 0);
        check("bp_valid_held", o_valid, 1);
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("bp_all_sent", idx, 10);

    // Random valid/ready on both sides.
    for (int c = 0; c < 60; c++) begin
      d_valid = 1'($urandom_range(0, 1));
      d_ordy  = 1'($urandom_range(0, 1));
      d_data  = 32'($urandom_range(0, 255));
      d_amt   = 5'($urandom_range(0, 7));
      d_op    = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
    d_ordy  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);
    check("rand_acc_eq_del", n_del, n_acc);

    // Full pipeline: accept and deliver every cycle.
    for (int c = 0; c < 23; c++) begin
      d_valid = 1'b1;
      d_ordy  = 1'b1;
      d_data  = 32'($urandom_range(0, 255));
      d_amt   = 5'($urandom_range(0, 7));
      d_op    = 3'($urandom_range(0, 7));
      #2;
      if (c >= 3) check("full_accept_deliver", {o_in_ready, o_valid}, 2'b11);
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("full_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Reset with three words in flight and the consumer stalled.
    d_ordy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d_valid = 1'b1;
      d_data  = 32'h40 + 32'(c);
      d_amt   = 5'(c);
      d_op    = 3'b000;
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
    check("rf_full_valid", o_valid, 1);
    check("rf_full_in_ready", o_in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rf_async_valid", o_valid, 0);
    check("rf_async_data", o_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rf_after_valid", o_valid, 0);
    nv = 0;
    add_vec(32'h96, 3, 3'b100, 32'hF2);
    burst(nv);

    // WIDTH=32: every amount for ROL and SRA on 0x8000_0001.
    sel32 = 1'b1;
    nv = 0;
    for (int a = 0; a < 32; a++) begin
      add_vec(32'h8000_0001, a, 3'b001, ref_op(32, 32'h8000_0001, a, 3'b001));
      add_vec(32'h8000_0001, a, 3'b100, ref_op(32, 32'h8000_0001, a, 3'b100));
    end
    burst(nv);
    sel32 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
